ibex_lsu_split: RTL and testbench
=================================

Name: ibex_lsu_split

Overview:
Load/store unit that sits directly upstream of the writeback stage. It takes one load or store per request from ID/EX and drives a single-outstanding data bus (req/gnt/rvalid). Misaligned accesses are split into two word transactions, and load data is realigned and sign/zero extended. The final response (data, write enable, valid, error) is delivered to writeback as rf_wdata_lsu, rf_we_lsu, lsu_resp_valid and lsu_resp_err.

Parameters:
ResetAll, 0, 1 = datapath capture registers (type, sign, we, offset, addr, rdata_q) are also reset; 0 = only state and error flag are reset.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; one clock, asynchronous, active-low
lsu_req_i  in  1  ID/EX request; held stable until lsu_req_done_o
lsu_we_i  in  1  1 = store
lsu_type_i  in  2  00 word, 01 half, 10 byte (11 treated as byte)
lsu_sign_ext_i  in  1  sign-extend load result
lsu_wdata_i  in  32  store data, LSB-aligned
adder_result_ex_i  in  32  byte address
lsu_req_done_o  out  1  last address phase granted; ID/EX may advance
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant
data_addr_o  out  32  word-aligned bus address
data_we_o  out  1  bus write
data_be_o  out  4  byte enables
data_wdata_o  out  32  bus write data
data_rvalid_i  in  1  response valid
data_err_i  in  1  response error
data_rdata_i  in  32  response data
lsu_rdata_o  out  32  realigned, extended load data
lsu_rdata_valid_o  out  1  load write enable to writeback
lsu_resp_valid_o  out  1  final response pulse
lsu_resp_err_o  out  1  final response had an error (either part)
busy_o  out  1  state != IDLE
addr_last_o  out  32  byte address of the most recently granted part

Behaviour:
- off = adder_result_ex_i[1:0], captured as off_q on acceptance.
- Split rules: word with off != 0 is split; half with off == 3 is split; byte is never split.
- First part is issued at adder_result_ex_i & ~3. Second part is issued at (first addr) + 4, with a 32-bit wrap.
- Byte enables, first part:
  - word: 1111 << off
  - half: 0011 << off, truncated to 4 bits
  - byte: 0001 << off
- Byte enables, second part:
  - word: off1 → 0001, off2 → 0011, off3 → 0111
  - half (off3): 0001
- data_wdata_o = lsu_wdata_i rotated left by 8*off, identical for both parts.
- FSM states: IDLE, WAIT_GNT_MIS, WAIT_RVALID_MIS, WAIT_GNT, WAIT_RVALID.
- IDLE:
  - data_req_o = lsu_req_i. Capture type, sign, we and off when lsu_req_i is high.
  - gnt & split → WAIT_RVALID_MIS.
  - gnt & !split → WAIT_RVALID, with lsu_req_done_o = 1 in that cycle.
  - no gnt → WAIT_GNT_MIS if split, else WAIT_GNT.
- WAIT_GNT_MIS: req = 1 on the first address. On gnt → WAIT_RVALID_MIS.
- WAIT_RVALID_MIS: req = 0. On rvalid: rdata_q <= data_rdata_i, err_q <= data_err_i, → WAIT_GNT with the second address.
- WAIT_GNT: req = 1. On gnt: lsu_req_done_o = 1 (combinational, same cycle) → WAIT_RVALID.
- WAIT_RVALID: req = 0. On rvalid:
  - lsu_resp_valid_o = 1 in the same cycle; → IDLE.
  - A new request may be issued from IDLE the following cycle.
- Address hold: data_addr_o, data_be_o and data_we_o stay stable while req = 1 and gnt = 0.
- Load data:
  - word = ({data_rdata_i, rdata_q} >> 8*off_q)[31:0] if split, else data_rdata_i >> 8*off_q.
  - Then half/byte results are extended from bit 15/7 when sign_q, else zero-filled.
- Response outputs:
  - lsu_resp_err_o = lsu_resp_valid_o & (err_q | data_err_i).
  - lsu_rdata_valid_o = lsu_resp_valid_o & ~we_q & ~lsu_resp_err_o.
- Errors: an error on the first part does not abort; the second part is still issued.
- addr_last_o: updated on every gnt to the exact byte address of that part (second part = aligned + 4). Holds otherwise.
- Latency: an aligned access with immediate gnt and rvalid the next cycle gives the response 1 cycle after the request.
- Protocol handling:
  - rvalid in IDLE, WAIT_GNT_MIS or WAIT_GNT is ignored.
  - gnt while req = 0 is ignored.
- Reset (also mid-transaction):
  - State → IDLE; err_q → 0.
  - All outputs 0 except data_addr_o, data_wdata_o and addr_last_o, which are 0 only when ResetAll.
  - An in-flight response is dropped; the bus is assumed to reset together with this block.

Test Plan:
- Aligned LW at 0x100, gnt same cycle, rvalid next cycle with rdata 0x8765_4321 → one bus request (addr 0x100, be 1111); lsu_rdata_o = 0x8765_4321; resp_valid and rdata_valid high for 1 cycle.
- LH sign-extended at 0x203, rdata1 0xAB00_0000, rdata2 0x0000_00CD → requests at 0x200 (be 1000) and 0x204 (be 0001); lsu_rdata_o = 0xFFFF_CDAB; done pulses on the second gnt.
- SW at 0x301, wdata 0x1122_3344, gnt delayed 3 cycles on each part → data_wdata_o = 0x2233_4411 on both parts; be 1110 then 0001; addr/be stable while waiting; rdata_valid stays 0.
- Split LW at 0x402 with data_err_i on the first rvalid only → second part is still issued; resp_err = 1; rdata_valid = 0; addr_last_o = 0x404.
- LBU at 0xFFFF_FFFF → be 1000; rdata 0x9A00_0000 gives 0x0000_009A. Split LW at 0xFFFF_FFFE → second address wraps to 0x0000_0000.
- rst_ni asserted in WAIT_RVALID_MIS → next cycle IDLE with all outputs 0; a following aligned LW completes normally.

Source files
------------

// File: rtl/ibex_lsu_split.sv
// rtl/ibex_lsu_split.sv - load/store unit with misaligned split, realignment and extension
module ibex_lsu_split #(
    parameter bit ResetAll = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [31:0] adder_result_ex_i,
    output logic        lsu_req_done_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_rdata_valid_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o,
    output logic        busy_o,
    output logic [31:0] addr_last_o
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GNT_MIS,
        WAIT_RVALID_MIS,
        WAIT_GNT,
        WAIT_RVALID
    } state_e;

    state_e      state_q;
    logic        err_q;

    logic [1:0]  type_q, type_d;
    logic        sign_q, sign_d;
    logic        we_q, we_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] addr_last_q, addr_last_d;

    function automatic logic is_split(input logic [1:0] t, input logic [1:0] o);
        case (t)
            2'b00:   return o != 2'b00;
            2'b01:   return o == 2'b11;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] be_first(input logic [1:0] t, input logic [1:0] o);
        logic [3:0] b;
        case (t)
            2'b00:   b = 4'b1111 << o;
            2'b01:   b = 4'b0011 << o;
            default: b = 4'b0001 << o;
        endcase
        return b;
    endfunction

    function automatic logic [3:0] be_second(input logic [1:0] t, input logic [1:0] o);
        logic [3:0] b;
        b = 4'b0000;
        if (t == 2'b00) begin
            case (o)
                2'b01:   b = 4'b0001;
                2'b10:   b = 4'b0011;
                2'b11:   b = 4'b0111;
                default: b = 4'b0000;
            endcase
        end else if (t == 2'b01) begin
            b = 4'b0001;
        end
        return b;
    endfunction

    logic [1:0]  off_in;
    logic [5:0]  wsh;
    logic [31:0] wdata_rot;
    logic        split_in;
    logic        split_q;

    assign off_in    = adder_result_ex_i[1:0];
    assign wsh       = {1'b0, off_in, 3'b000};
    assign wdata_rot = (lsu_wdata_i << wsh) | (lsu_wdata_i >> (6'd32 - wsh));
    assign split_in  = is_split(lsu_type_i, off_in);
    assign split_q   = is_split(type_q, off_q);

    // Bus side: IDLE presents the incoming request directly, later states replay captured values.
    always_comb begin
        data_req_o       = 1'b0;
        data_addr_o      = addr_q;
        data_be_o        = 4'b0000;
        data_we_o        = 1'b0;
        data_wdata_o     = wdata_q;
        lsu_req_done_o   = 1'b0;
        lsu_resp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                data_req_o = lsu_req_i;
                if (lsu_req_i) begin
                    data_addr_o    = {adder_result_ex_i[31:2], 2'b00};
                    data_be_o      = be_first(lsu_type_i, off_in);
                    data_we_o      = lsu_we_i;
                    data_wdata_o   = wdata_rot;
                    lsu_req_done_o = data_gnt_i & ~split_in;
                end
            end
            WAIT_GNT_MIS: begin
                data_req_o = 1'b1;
                data_be_o  = be_first(type_q, off_q);
                data_we_o  = we_q;
            end
            WAIT_GNT: begin
                data_req_o     = 1'b1;
                data_be_o      = split_q ? be_second(type_q, off_q) : be_first(type_q, off_q);
                data_we_o      = we_q;
                lsu_req_done_o = data_gnt_i;
            end
            WAIT_RVALID: begin
                lsu_resp_valid_o = data_rvalid_i;
            end
            default: ;
        endcase
    end

    logic [5:0]  rsh;
    logic [31:0] rd_hi, rd_lo, rd_word, rd_ext;

    assign rsh     = {1'b0, off_q, 3'b000};
    assign rd_hi   = split_q ? data_rdata_i : 32'h0;
    assign rd_lo   = split_q ? rdata_q : data_rdata_i;
    assign rd_word = (rd_lo >> rsh) | (rd_hi << (6'd32 - rsh));

    always_comb begin
        case (type_q)
            2'b00:   rd_ext = rd_word;
            2'b01:   rd_ext = {{16{sign_q & rd_word[15]}}, rd_word[15:0]};
            default: rd_ext = {{24{sign_q & rd_word[7]}}, rd_word[7:0]};
        endcase
    end

    assign lsu_rdata_o       = lsu_resp_valid_o ? rd_ext : 32'h0;
    assign lsu_resp_err_o    = lsu_resp_valid_o & (err_q | data_err_i);
    assign lsu_rdata_valid_o = lsu_resp_valid_o & ~we_q & ~lsu_resp_err_o;
    assign busy_o            = state_q != IDLE;
    assign addr_last_o       = addr_last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lsu_req_i) begin
                        err_q <= 1'b0;
                        if (data_gnt_i) state_q <= split_in ? WAIT_RVALID_MIS : WAIT_RVALID;
                        else            state_q <= split_in ? WAIT_GNT_MIS : WAIT_GNT;
                    end
                end
                WAIT_GNT_MIS: if (data_gnt_i) state_q <= WAIT_RVALID_MIS;
                WAIT_RVALID_MIS: begin
                    if (data_rvalid_i) begin
                        err_q   <= data_err_i;
                        state_q <= WAIT_GNT;
                    end
                end
                WAIT_GNT: if (data_gnt_i) state_q <= WAIT_RVALID;
                WAIT_RVALID: begin
                    if (data_rvalid_i) begin
                        err_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        type_d      = type_q;
        sign_d      = sign_q;
        we_d        = we_q;
        off_d       = off_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        addr_last_d = addr_last_q;
        if (state_q == IDLE && lsu_req_i) begin
            type_d  = lsu_type_i;
            sign_d  = lsu_sign_ext_i;
            we_d    = lsu_we_i;
            off_d   = off_in;
            addr_d  = {adder_result_ex_i[31:2], 2'b00};
            wdata_d = wdata_rot;
        end
        if (state_q == WAIT_RVALID_MIS && data_rvalid_i) begin
            rdata_d = data_rdata_i;
            addr_d  = addr_q + 32'd4;
        end
        // The second part reports its aligned address; every first part reports the true byte address.
        if (data_req_o && data_gnt_i) begin
            case (state_q)
                IDLE:     addr_last_d = adder_result_ex_i;
                WAIT_GNT: addr_last_d = split_q ? addr_q : {addr_q[31:2], off_q};
                default:  addr_last_d = {addr_q[31:2], off_q};
            endcase
        end
    end

    generate
        if (ResetAll) begin : g_dp_rst
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    type_q      <= 2'b00;
                    sign_q      <= 1'b0;
                    we_q        <= 1'b0;
                    off_q       <= 2'b00;
                    addr_q      <= 32'h0;
                    wdata_q     <= 32'h0;
                    rdata_q     <= 32'h0;
                    addr_last_q <= 32'h0;
                end else begin
                    type_q      <= type_d;
                    sign_q      <= sign_d;
                    we_q        <= we_d;
                    off_q       <= off_d;
                    addr_q      <= addr_d;
                    wdata_q     <= wdata_d;
                    rdata_q     <= rdata_d;
                    addr_last_q <= addr_last_d;
                end
            end
        end else begin : g_dp_nrst
            always_ff @(posedge clk_i) begin
                type_q      <= type_d;
                sign_q      <= sign_d;
                we_q        <= we_d;
                off_q       <= off_d;
                addr_q      <= addr_d;
                wdata_q     <= wdata_d;
                rdata_q     <= rdata_d;
                addr_last_q <= addr_last_d;
            end
        end
    endgenerate

endmodule

// File: tb/tb_ibex_lsu_split.sv
// tb/tb_ibex_lsu_split.sv - directed self-checking bench for ibex_lsu_split
module tb_ibex_lsu_split;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_req, lsu_we, lsu_sign;
    logic [1:0]  lsu_type;
    logic [31:0] lsu_wdata, adder;
    logic        req_done, data_req, data_gnt, data_we, data_rvalid, data_err;
    logic [31:0] data_addr, data_wdata, data_rdata, lsu_rdata, addr_last;
    logic [3:0]  data_be;
    logic        rdata_valid, resp_valid, resp_err, busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_wd;
    logic        exp_we;

    always #5 clk = ~clk;

    ibex_lsu_split #(.ResetAll(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_type_i(lsu_type),
        .lsu_sign_ext_i(lsu_sign), .lsu_wdata_i(lsu_wdata), .adder_result_ex_i(adder),
        .lsu_req_done_o(req_done),
        .data_req_o(data_req), .data_gnt_i(data_gnt), .data_addr_o(data_addr),
        .data_we_o(data_we), .data_be_o(data_be), .data_wdata_o(data_wdata),
        .data_rvalid_i(data_rvalid), .data_err_i(data_err), .data_rdata_i(data_rdata),
        .lsu_rdata_o(lsu_rdata), .lsu_rdata_valid_o(rdata_valid),
        .lsu_resp_valid_o(resp_valid), .lsu_resp_err_o(resp_err),
        .busy_o(busy), .addr_last_o(addr_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus part: dly cycles without grant, the grant cycle, then the rvalid cycle (left at its negedge).
    task automatic part(input string tag, input logic [31:0] a, input logic [3:0] be, input int dly,
                        input logic last, input logic [31:0] rd, input logic er);
        data_rvalid = 1'b0;
        data_gnt    = 1'b0;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            check({tag, " wait req"},  32'(data_req), 32'd1);
            check({tag, " wait addr"}, data_addr, a);
            check({tag, " wait be"},   32'(data_be), 32'(be));
            check({tag, " wait done"}, 32'(req_done), 32'd0);
            tick();
        end
        data_gnt = 1'b1;
        @(negedge clk);
        check({tag, " req"},   32'(data_req), 32'd1);
        check({tag, " addr"},  data_addr, a);
        check({tag, " be"},    32'(data_be), 32'(be));
        check({tag, " we"},    32'(data_we), 32'(exp_we));
        check({tag, " wdata"}, data_wdata, exp_wd);
        check({tag, " done"},  32'(req_done), 32'(last));
        tick();
        if (last) lsu_req = 1'b0;
        data_gnt    = 1'b0;
        data_rvalid = 1'b1;
        data_rdata  = rd;
        data_err    = er;
        @(negedge clk);
        check({tag, " idle req"}, 32'(data_req), 32'd0);
        if (!last) check({tag, " early resp"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic start(input logic we, input logic [1:0] t, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rot);
        lsu_req = 1'b1; lsu_we = we; lsu_type = t; lsu_sign = sg;
        adder = a; lsu_wdata = wd; exp_wd = exp_rot; exp_we = we;
    endtask

    task automatic finish_resp(input string tag, input logic [31:0] rd, input logic rv, input logic er);
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, " rdata"},      lsu_rdata, rd);
        check({tag, " rdata_valid"}, 32'(rdata_valid), 32'(rv));
        check({tag, " resp_err"},   32'(resp_err), 32'(er));
        tick();
        data_rvalid = 1'b0; data_err = 1'b0;
        @(negedge clk);
        check({tag, " resp drop"}, 32'(resp_valid), 32'd0);
        check({tag, " busy"},      32'(busy), 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_type = 2'b00; lsu_sign = 1'b0;
        lsu_wdata = 32'h0; adder = 32'h0; data_gnt = 1'b0; data_rvalid = 1'b0;
        data_err = 1'b0; data_rdata = 32'h0; exp_wd = 32'h0; exp_we = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("rst req",   32'(data_req), 32'd0);
        check("rst busy",  32'(busy), 32'd0);
        check("rst addr",  data_addr, 32'h0);
        check("rst last",  addr_last, 32'h0);
        check("rst wdata", data_wdata, 32'h0);
        tick();
        rst_n = 1'b1;

        // stray rvalid and gnt in IDLE are ignored
        data_rvalid = 1'b1; data_gnt = 1'b1; data_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("stray resp", 32'(resp_valid), 32'd0);
        tick();
        data_rvalid = 1'b0; data_gnt = 1'b0;
        @(negedge clk);
        check("stray busy", 32'(busy), 32'd0);
        tick();

        start(1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0, 32'h0);
        part("lw", 32'h0000_0100, 4'b1111, 0, 1'b1, 32'h8765_4321, 1'b0);
        finish_resp("lw", 32'h8765_4321, 1'b1, 1'b0);
        check("lw last", addr_last, 32'h0000_0100);

        start(1'b0, 2'b01, 1'b1, 32'h0000_0203, 32'h0, 32'h0);
        part("lh1", 32'h0000_0200, 4'b1000, 0, 1'b0, 32'hAB00_0000, 1'b0);
        tick();
        part("lh2", 32'h0000_0204, 4'b0001, 0, 1'b1, 32'h0000_00CD, 1'b0);
        finish_resp("lh", 32'hFFFF_CDAB, 1'b1, 1'b0);

        start(1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'h1122_3344, 32'h2233_4411);
        part("sw1", 32'h0000_0300, 4'b1110, 3, 1'b0, 32'h0, 1'b0);
        tick();
        part("sw2", 32'h0000_0304, 4'b0001, 3, 1'b1, 32'h0, 1'b0);
        finish_resp("sw", 32'h0, 1'b0, 1'b0);

        start(1'b0, 2'b00, 1'b0, 32'h0000_0402, 32'h0, 32'h0);
        part("err1", 32'h0000_0400, 4'b1100, 1, 1'b0, 32'h1111_1111, 1'b1);
        tick();
        part("err2", 32'h0000_0404, 4'b0011, 0, 1'b1, 32'h2222_2222, 1'b0);
        finish_resp("err", 32'h2222_1111, 1'b0, 1'b1);
        check("err last", addr_last, 32'h0000_0404);

        start(1'b0, 2'b01, 1'b1, 32'h0000_0502, 32'h0, 32'h0);
        part("lh_al", 32'h0000_0500, 4'b1100, 2, 1'b1, 32'h8001_1234, 1'b0);
        finish_resp("lh_al", 32'hFFFF_8001, 1'b1, 1'b0);

        start(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0);
        part("lbu", 32'hFFFF_FFFC, 4'b1000, 0, 1'b1, 32'h9A00_0000, 1'b0);
        finish_resp("lbu", 32'h0000_009A, 1'b1, 1'b0);
        check("lbu last", addr_last, 32'hFFFF_FFFF);

        start(1'b0, 2'b00, 1'b0, 32'hFFFF_FFFE, 32'h0, 32'h0);
        part("wrap1", 32'hFFFF_FFFC, 4'b1100, 0, 1'b0, 32'hBBAA_0000, 1'b0);
        tick();
        part("wrap2", 32'h0000_0000, 4'b0011, 0, 1'b1, 32'h0000_DDCC, 1'b0);
        finish_resp("wrap", 32'hDDCC_BBAA, 1'b1, 1'b0);
        check("wrap last", addr_last, 32'h0000_0000);

        // reset while waiting for the first response of a split load
        start(1'b0, 2'b00, 1'b0, 32'h0000_0402, 32'h0, 32'h0);
        data_gnt = 1'b1;
        tick();
        data_gnt = 1'b0;
        @(negedge clk);
        check("mid busy", 32'(busy), 32'd1);
        tick();
        rst_n = 1'b0; lsu_req = 1'b0; adder = 32'h0;
        @(negedge clk);
        check("mrst busy", 32'(busy), 32'd0);
        check("mrst req",  32'(data_req), 32'd0);
        check("mrst addr", data_addr, 32'h0);
        check("mrst be",   32'(data_be), 32'd0);
        check("mrst last", addr_last, 32'h0);
        check("mrst resp", 32'(resp_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        start(1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0, 32'h0);
        part("post", 32'h0000_0100, 4'b1111, 0, 1'b1, 32'h1357_9BDF, 1'b0);
        finish_resp("post", 32'h1357_9BDF, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
